// File: rtl/i2c_slave_regmap_if.sv
// ----------------------------------------------------------------------------
// i2c_slave_regmap_if
// Register-access bus between the I2C slave front end and a register file.
//   reg_addr  : register pointer presented with reg_we / reg_re
//   reg_wdata : write data, valid with reg_we
//   reg_we    : one-cycle write strobe
//   reg_re    : one-cycle read strobe
//   reg_rdata : read data, valid exactly one clk after reg_re
// Modports:
//   master : the I2C slave (drives address/data/strobes, receives read data)
//   slave  : the register file
// ----------------------------------------------------------------------------
interface i2c_slave_regmap_if #(
    parameter int REG_AW = 8
);
    logic [REG_AW-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [7:0]        reg_rdata;

    modport master (
        output reg_addr,
        output reg_wdata,
        output reg_we,
        output reg_re,
        input  reg_rdata
    );

    modport slave (
        input  reg_addr,
        input  reg_wdata,
        input  reg_we,
        input  reg_re,
        output reg_rdata
    );
endinterface

// File: rtl/i2c_slave_regmap.sv
// ----------------------------------------------------------------------------
// i2c_slave_regmap
// I2C slave that maps bus transfers onto a simple register interface.
// Write: S <dev,W> <ptr bytes> <data>* P  -> one reg_we per data byte.
// Read : S <dev,R> <data>* (master ACK/NACK) -> one reg_re per byte.
// The register pointer auto-increments after every access and wraps.
// Ports:
//   clk, rst  : system clock, synchronous active-high reset
//   dev_addr  : own 7-bit device address
//   scl_i     : SCL input (asynchronous)
//   sda_i     : SDA input (asynchronous)
//   sda_o     : SDA drive value, always 0 (open drain)
//   sda_oen   : 1 = pull SDA low, 0 = release
//   busy      : high between START and STOP
//   regs      : register bus (master modport)
// Parameters:
//   FILT_LEN   : samples a changed input must hold before the filter follows
//   REG_ABYTES : pointer bytes per write (1 or 2)
// ----------------------------------------------------------------------------
module i2c_slave_regmap #(
    parameter int FILT_LEN   = 3,
    parameter int REG_ABYTES = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [6:0]                dev_addr,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      sda_o,
    output logic                      sda_oen,
    output logic                      busy,
    i2c_slave_regmap_if.master        regs
);
    localparam int REG_AW = 8 * REG_ABYTES;

    typedef enum logic [2:0] {
        IDLE,
        DEV_ADDR,
        PTR,
        WR_DATA,
        RD_DATA,
        MACK,
        IGNORE
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning: bit 0 = SCL, bit 1 = SDA.
    // ------------------------------------------------------------------
    logic [1:0] raw_in;
    logic [1:0] filt;
    logic [1:0] filt_prev;

    assign raw_in = {sda_i, scl_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_filt
            logic       sync1_q, sync2_q;
            logic       filt_q, filt_d;
            logic       prev_q;
            logic [3:0] cnt_q, cnt_d;

            // The output only follows the synchronised input once it has
            // disagreed for FILT_LEN consecutive samples; any agreeing
            // sample restarts the count, so shorter glitches vanish.
            always_comb begin
                cnt_d  = '0;
                filt_d = filt_q;
                if (sync2_q != filt_q) begin
                    if (cnt_q == 4'(FILT_LEN - 1)) begin
                        filt_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_q <= 1'b1;
                    sync2_q <= 1'b1;
                    filt_q  <= 1'b1;
                    prev_q  <= 1'b1;
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= raw_in[gi];
                    sync2_q <= sync1_q;
                    filt_q  <= filt_d;
                    prev_q  <= filt_q;
                    cnt_q   <= cnt_d;
                end
            end

            assign filt[gi]      = filt_q;
            assign filt_prev[gi] = prev_q;
        end
    endgenerate

    logic scl_f, sda_f;
    logic scl_rise, scl_fall, sda_rise, sda_fall;
    logic start_det, stop_det;

    assign scl_f     = filt[0];
    assign sda_f     = filt[1];
    assign scl_rise  =  filt[0] & ~filt_prev[0];
    assign scl_fall  = ~filt[0] &  filt_prev[0];
    assign sda_rise  =  filt[1] & ~filt_prev[1];
    assign sda_fall  = ~filt[1] &  filt_prev[1];
    assign start_det = sda_fall & scl_f;
    assign stop_det  = sda_rise & scl_f;

    // ------------------------------------------------------------------
    // Protocol state
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic              got8_q, got8_d;     // 8 bits in, ACK slot starts at next SCL fall
    logic              ack_q, ack_d;       // inside the 9th (ACK) bit of a received byte
    logic              pbyte_q, pbyte_d;   // pointer byte index
    logic [7:0]        shift_q, shift_d;   // receive shift register
    logic [7:0]        tx_q, tx_d;         // transmit shift register
    logic              rd_load_q, rd_load_d;
    logic [REG_AW-1:0] ptr_q, ptr_d;
    logic              sda_oen_q, sda_oen_d;
    logic              busy_q, busy_d;
    logic              reg_we_q, reg_we_d;
    logic              reg_re_q, reg_re_d;
    logic [REG_AW-1:0] reg_addr_q, reg_addr_d;
    logic [7:0]        reg_wdata_q, reg_wdata_d;

    logic [REG_AW-1:0] ptr_load;
    logic [REG_AW-1:0] ptr_inc;
    logic              last_pbyte;

    // Pointer bytes arrive MSB first, so each new byte shifts in at the bottom.
    generate
        if (REG_ABYTES == 1) begin : g_ptr1
            assign ptr_load = shift_q;
        end else begin : g_ptr2
            assign ptr_load = {ptr_q[REG_AW-9:0], shift_q};
        end
    endgenerate

    assign ptr_inc    = ptr_q + REG_AW'(1);
    assign last_pbyte = (REG_ABYTES == 1) || pbyte_q;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        got8_d      = got8_q;
        ack_d       = ack_q;
        pbyte_d     = pbyte_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        ptr_d       = ptr_q;
        sda_oen_d   = sda_oen_q;
        busy_d      = busy_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;
        // Read data is valid the cycle after reg_re; capture it then.
        rd_load_d   = reg_re_q;
        if (rd_load_q) begin
            tx_d = regs.reg_rdata;
        end

        if (stop_det) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            sda_oen_d = 1'b0;
            bit_cnt_d = '0;
            got8_d    = 1'b0;
            ack_d     = 1'b0;
        end else if (start_det) begin
            // Also covers repeated START; the pointer is deliberately kept.
            state_d   = DEV_ADDR;
            busy_d    = 1'b1;
            sda_oen_d = 1'b0;
            bit_cnt_d = '0;
            got8_d    = 1'b0;
            ack_d     = 1'b0;
            pbyte_d   = 1'b0;
        end else if (scl_rise) begin
            case (state_q)
                DEV_ADDR, PTR, WR_DATA, RD_DATA: begin
                    // The master samples our ACK on this rise; nothing to shift.
                    if (!ack_q) begin
                        shift_d   = {shift_q[6:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            got8_d = 1'b1;
                        end
                    end
                end
                MACK: begin
                    if (!sda_f) begin
                        state_d    = RD_DATA;
                        reg_re_d   = 1'b1;
                        reg_addr_d = ptr_q;
                        ptr_d      = ptr_inc;
                    end else begin
                        state_d = IGNORE;
                    end
                end
                default: ;
            endcase
        end else if (scl_fall) begin
            if (got8_q) begin
                got8_d = 1'b0;
                case (state_q)
                    DEV_ADDR: begin
                        if (shift_q[7:1] == dev_addr) begin
                            ack_d     = 1'b1;
                            sda_oen_d = 1'b1;
                            if (shift_q[0]) begin
                                reg_re_d   = 1'b1;
                                reg_addr_d = ptr_q;
                                ptr_d      = ptr_inc;
                            end
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                    PTR: begin
                        ack_d     = 1'b1;
                        sda_oen_d = 1'b1;
                        ptr_d     = ptr_load;
                    end
                    WR_DATA: begin
                        ack_d       = 1'b1;
                        sda_oen_d   = 1'b1;
                        reg_we_d    = 1'b1;
                        reg_addr_d  = ptr_q;
                        reg_wdata_d = shift_q;
                        ptr_d       = ptr_inc;
                    end
                    RD_DATA: begin
                        // Byte fully sent: free SDA for the master's ACK/NACK.
                        sda_oen_d = 1'b0;
                        state_d   = MACK;
                    end
                    default: ;
                endcase
            end else if (ack_q) begin
                ack_d     = 1'b0;
                sda_oen_d = 1'b0;
                case (state_q)
                    DEV_ADDR: begin
                        if (shift_q[0]) begin
                            // End of address ACK doubles as first data-bit slot.
                            state_d   = RD_DATA;
                            sda_oen_d = ~tx_q[7];
                            tx_d      = {tx_q[6:0], 1'b0};
                        end else begin
                            state_d = PTR;
                            pbyte_d = 1'b0;
                        end
                    end
                    PTR: begin
                        if (last_pbyte) begin
                            state_d = WR_DATA;
                        end else begin
                            pbyte_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else if (state_q == RD_DATA) begin
                sda_oen_d = ~tx_q[7];
                tx_d      = {tx_q[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            got8_q      <= 1'b0;
            ack_q       <= 1'b0;
            pbyte_q     <= 1'b0;
            shift_q     <= '0;
            tx_q        <= '0;
            rd_load_q   <= 1'b0;
            ptr_q       <= '0;
            sda_oen_q   <= 1'b0;
            busy_q      <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            got8_q      <= got8_d;
            ack_q       <= ack_d;
            pbyte_q     <= pbyte_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            rd_load_q   <= rd_load_d;
            ptr_q       <= ptr_d;
            sda_oen_q   <= sda_oen_d;
            busy_q      <= busy_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
        end
    end

    assign sda_o          = 1'b0;
    assign sda_oen        = sda_oen_q;
    assign busy           = busy_q;
    assign regs.reg_we    = reg_we_q;
    assign regs.reg_re    = reg_re_q;
    assign regs.reg_addr  = reg_addr_q;
    assign regs.reg_wdata = reg_wdata_q;
endmodule
